// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//
// Shares a single UART transmitter between N = 2**ID_W requesters. Each
// requester offers one byte at a time (req level + req_data). The arbiter
// picks a winner round-robin, latches the byte onto tx_data, pulses tx_start
// and ack, then waits for tx_done. A requester holding lock keeps the
// transmitter across consecutive bytes. A watchdog returns to IDLE if the
// transmitter never completes.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   req[N]        per-requester byte valid (level, held until acked)
//   req_data[8N]  byte for requester i on bits [8i+7:8i]
//   lock[N]       requester i keeps the grant after its byte completes
//   ack[N]        one-cycle pulse: requester's byte was taken
//   tx_start      one-cycle start pulse to the transmitter
//   tx_data[8]    byte being transmitted, stable until completion
//   tx_done       one-cycle completion pulse from the transmitter
//   grant_id      index of the current/last granted requester
//   busy          high while not IDLE
//   timeout_err   one-cycle pulse on watchdog expiry
module uart_tx_arbiter #(
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 120000,
    parameter int TO_W    = 17
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2**ID_W-1:0]       req,
    input  logic [8*(2**ID_W)-1:0]   req_data,
    input  logic [2**ID_W-1:0]       lock,
    output logic [2**ID_W-1:0]       ack,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    input  logic                     tx_done,
    output logic [ID_W-1:0]          grant_id,
    output logic                     busy,
    output logic                     timeout_err
);

    localparam int N = 2**ID_W;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] ptr_q, ptr_d;
    logic [ID_W-1:0] grant_q, grant_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]    ack_q, ack_d;
    logic            tx_start_q, tx_start_d;
    logic [7:0]      tx_data_q, tx_data_d;
    logic            timeout_err_q, timeout_err_d;

    logic [ID_W-1:0] sel;
    logic [ID_W-1:0] idx;
    logic            sel_vld;
    logic            done_ok;
    logic            keep_grant;
    logic            at_limit;
    logic            issue;
    logic [ID_W-1:0] issue_id;
    logic            release_grant;
    logic            expire;

    // Round-robin pick: scan offsets from the far end so the smallest
    // offset from ptr (highest priority) is the last writer and wins.
    always_comb begin
        sel     = ptr_q;
        sel_vld = 1'b0;
        idx     = ptr_q;
        for (int i = N - 1; i >= 0; i--) begin
            idx = ptr_q + ID_W'(i);
            if (req[idx]) begin
                sel     = idx;
                sel_vld = 1'b1;
            end
        end
    end

    // A completion is only credible once the counter has left 0, i.e. not in
    // the same cycle the start pulse is being presented.
    assign done_ok    = tx_done && (cnt_q != '0);
    assign keep_grant = lock[grant_q] && req[grant_q];
    assign at_limit   = (cnt_q == TO_W'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ptr_q         <= '0;
            grant_q       <= '0;
            cnt_q         <= '0;
            ack_q         <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            grant_q       <= grant_d;
            cnt_q         <= cnt_d;
            ack_q         <= ack_d;
            tx_start_q    <= tx_start_d;
            tx_data_q     <= tx_data_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic; also classifies the edge into issue / release / expire.
    always_comb begin
        state_d       = state_q;
        issue         = 1'b0;
        issue_id      = grant_q;
        release_grant = 1'b0;
        expire        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sel_vld) begin
                    issue    = 1'b1;
                    issue_id = sel;
                    state_d  = S_SEND;
                end
            end
            S_SEND: begin
                // Completion takes precedence over a coincident watchdog expiry.
                if (done_ok) begin
                    if (keep_grant) begin
                        issue    = 1'b1;
                        issue_id = grant_q;
                    end else begin
                        release_grant = 1'b1;
                        state_d       = S_IDLE;
                    end
                end else if (at_limit) begin
                    expire        = 1'b1;
                    release_grant = 1'b1;
                    state_d       = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        ack_d         = '0;
        tx_start_d    = 1'b0;
        tx_data_d     = tx_data_q;
        grant_d       = grant_q;
        ptr_d         = ptr_q;
        timeout_err_d = expire;
        cnt_d         = (state_q == S_SEND) ? cnt_q + TO_W'(1) : cnt_q;
        if (issue) begin
            grant_d    = issue_id;
            tx_data_d  = req_data[{issue_id, 3'b000} +: 8];
            tx_start_d = 1'b1;
            ack_d      = N'(1) << issue_id;
            cnt_d      = '0;
        end
        // The requester just served drops to lowest priority.
        if (release_grant) begin
            ptr_d = grant_q + ID_W'(1);
        end
    end

    assign ack         = ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign grant_id    = grant_q;
    assign busy        = (state_q == S_SEND);
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed scenarios followed by randomized
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_uart_tx_arbiter;

    localparam int ID_W    = 2;
    localparam int N       = 4;
    localparam int TIMEOUT = 120;
    localparam int TO_W    = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [N-1:0]     req;
    logic [8*N-1:0]   req_data;
    logic [N-1:0]     lock;
    logic [N-1:0]     ack;
    logic             tx_start;
    logic [7:0]       tx_data;
    logic             tx_done;
    logic [ID_W-1:0]  grant_id;
    logic             busy;
    logic             timeout_err;

    uart_tx_arbiter #(
        .ID_W    (ID_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .lock        (lock),
        .ack         (ack),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_done     (tx_done),
        .grant_id    (grant_id),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: who owns the transmitter, how long the current byte
    // has been in flight, and which requester has top priority next.
    bit           m_busy;
    int           m_grant;
    int           m_ptr;
    int           m_elapsed;
    logic [N-1:0] m_ack;
    bit           m_start;
    bit           m_err;
    logic [7:0]   m_data;
    bit           auto_req;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_grant = 0; m_ptr = 0; m_elapsed = 0;
        m_ack = '0; m_start = 0; m_err = 0; m_data = '0;
    endtask

    task automatic model_issue(input int s);
        m_grant   = s;
        m_data    = req_data[8*s +: 8];
        m_start   = 1;
        m_ack     = N'(1) << s;
        m_elapsed = 0;
        m_busy    = 1;
    endtask

    // What the next rising edge should do, given the inputs now applied.
    task automatic model_edge();
        int  e;
        bit  found;
        m_start = 0; m_ack = '0; m_err = 0;
        if (!m_busy) begin
            found = 0;
            for (int i = 0; i < N; i++) begin
                if (!found && req[(m_ptr + i) % N]) begin
                    found = 1;
                    model_issue((m_ptr + i) % N);
                end
            end
        end else begin
            e = m_elapsed;
            m_elapsed = e + 1;
            if (tx_done && e >= 1) begin
                if (lock[m_grant] && req[m_grant]) model_issue(m_grant);
                else begin
                    m_ptr  = (m_grant + 1) % N;
                    m_busy = 0;
                end
            end else if (e == TIMEOUT - 1) begin
                m_err  = 1;
                m_ptr  = (m_grant + 1) % N;
                m_busy = 0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("ack",         32'(ack),         32'(m_ack));
        chk("tx_start",    32'(tx_start),    32'(m_start));
        chk("tx_data",     32'(tx_data),     32'(m_data));
        chk("grant_id",    32'(grant_id),    32'(m_grant));
        chk("busy",        32'(busy),        32'(m_busy));
        chk("timeout_err", 32'(timeout_err), 32'(m_err));
        if (auto_req) begin
            for (int i = 0; i < N; i++) begin
                if (m_ack[i]) begin
                    req_data[8*i +: 8] = 8'($urandom);
                    if ($urandom_range(0, 1) == 1) req[i] = 1'b0;
                end
            end
        end
    endtask

    // Transmitter that completes c cycles after the start edge.
    task automatic run_byte(input int c);
        tx_done = 1'b0;
        repeat (c - 1) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
    endtask

    // Asynchronous reset asserted between clock edges; outputs must clear at once.
    task automatic do_reset();
        rst = 1'b1;
        req = '0; lock = '0; tx_done = 1'b0;
        #1;
        chk("rst_ack",      32'(ack),         32'd0);
        chk("rst_tx_start", 32'(tx_start),    32'd0);
        chk("rst_tx_data",  32'(tx_data),     32'd0);
        chk("rst_grant",    32'(grant_id),    32'd0);
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_err",      32'(timeout_err), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    int order [5] = '{0, 1, 2, 3, 0};

    initial begin
        req = '0; req_data = '0; lock = '0; tx_done = 1'b0; auto_req = 0;
        do_reset();

        // Single request from requester 2, 100-cycle byte
        req_data[23:16] = 8'hA5;
        req = 4'b0100;
        step();
        chk("t1_start", 32'(tx_start), 32'd1);
        chk("t1_ack",   32'(ack),      32'h4);
        chk("t1_data",  32'(tx_data),  32'hA5);
        chk("t1_grant", 32'(grant_id), 32'd2);
        req = '0;
        run_byte(100);
        chk("t1_busy_low", 32'(busy), 32'd0);
        // ptr is now 3: requester 3 beats requester 0
        req = 4'b1001;
        step();
        chk("t1_ptr3", 32'(grant_id), 32'd3);
        req = '0;
        run_byte(5);

        // Unlocked round robin with all requesters active
        do_reset();
        req_data = 32'h44332211;
        req = 4'b1111;
        step();
        chk("t2_grant0", 32'(grant_id), 32'd0);
        for (int k = 1; k < 5; k++) begin
            run_byte(50);
            chk("t2_gap_start", 32'(tx_start), 32'd0);
            chk("t2_gap_busy",  32'(busy),     32'd0);
            step();
            chk("t2_next_start", 32'(tx_start), 32'd1);
            chk("t2_order",      32'(grant_id), 32'(order[k]));
        end
        req = '0;
        run_byte(50);

        // Locked burst from requester 1, then handover to 3
        do_reset();
        lock = 4'b0010;
        req_data[15:8]  = 8'h11;
        req_data[31:24] = 8'h77;
        req = 4'b1010;
        step();
        chk("t3_g1",  32'(grant_id), 32'd1);
        chk("t3_b11", 32'(tx_data),  32'h11);
        req_data[15:8] = 8'h22;
        run_byte(10);
        chk("t3_b2b_start", 32'(tx_start), 32'd1);
        chk("t3_b22",       32'(tx_data),  32'h22);
        req_data[15:8] = 8'h33;
        run_byte(10);
        chk("t3_b2b_start2", 32'(tx_start), 32'd1);
        chk("t3_b33",        32'(tx_data),  32'h33);
        req[1] = 1'b0;
        run_byte(10);
        chk("t3_idle", 32'(busy), 32'd0);
        step();
        chk("t3_g3",  32'(grant_id), 32'd3);
        chk("t3_b77", 32'(tx_data),  32'h77);
        req[3] = 1'b0;
        run_byte(10);
        // Lock dropped mid-byte releases the grant at completion
        req_data[15:8] = 8'h44;
        req = 4'b1010;
        step();
        chk("t3b_g1", 32'(grant_id), 32'd1);
        req_data[15:8] = 8'h22;
        run_byte(10);
        chk("t3b_b22", 32'(tx_data), 32'h22);
        req_data[15:8] = 8'h33;
        repeat (4) step();
        lock[1] = 1'b0;
        repeat (5) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t3b_release", 32'(busy), 32'd0);
        step();
        chk("t3b_g3", 32'(grant_id), 32'd3);
        req = '0;
        run_byte(10);

        // Watchdog: transmitter never completes
        do_reset();
        req = 4'b0001;
        step();
        req = 4'b0010;
        repeat (TIMEOUT - 1) begin
            step();
            chk("t4_no_err", 32'(timeout_err), 32'd0);
        end
        step();
        chk("t4_err",  32'(timeout_err), 32'd1);
        chk("t4_idle", 32'(busy),        32'd0);
        step();
        chk("t4_err_pulse", 32'(timeout_err), 32'd0);
        chk("t4_next",      32'(grant_id),    32'd1);
        req = '0;
        run_byte(5);

        // tx_done with tx_start ignored; tx_done at the limit wins
        do_reset();
        req = 4'b0001;
        step();
        req = '0;
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t5_ignored", 32'(busy), 32'd1);
        repeat (TIMEOUT - 2) step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        chk("t5_no_err", 32'(timeout_err), 32'd0);
        chk("t5_done",   32'(busy),        32'd0);

        // Asynchronous reset mid-SEND, then ptr restarts at 0
        do_reset();
        req = 4'b0100;
        step();
        req = '0;
        run_byte(5);
        req = 4'b1111;
        step();
        chk("t6_g3", 32'(grant_id), 32'd3);
        step();
        do_reset();
        req = 4'b1111;
        step();
        chk("t6_g0", 32'(grant_id), 32'd0);
        req = '0;
        run_byte(5);

        // Randomized traffic
        do_reset();
        auto_req = 1;
        repeat (3000) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                    req_data[8*i +: 8] = 8'($urandom);
                end
            end
            lock    = N'($urandom_range(0, 15));
            tx_done = ($urandom_range(0, 11) == 0);
            step();
        end
        auto_req = 0;
        req = '0;
        tx_done = 1'b0;
        repeat (TIMEOUT + 5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
